// File: rtl/puf_capture_ctrl_pkg.sv
// Shared definitions for the PUF capture controller: FSM encoding,
// settings-register offsets and control-word bit positions.
package puf_capture_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SKIP    = 3'd1,
      ST_CAPTURE = 3'd2,
      ST_DRAIN   = 3'd3,
      ST_DONE    = 3'd4
   } state_e;

   localparam logic [7:0] SR_CTRL    = 8'd0;
   localparam logic [7:0] SR_SKIP    = 8'd1;
   localparam logic [7:0] SR_LEN     = 8'd2;
   localparam logic [7:0] SR_TIMEOUT = 8'd3;

   localparam int CTRL_START_BIT = 0;
   localparam int CTRL_ABORT_BIT = 1;

   // Absolute settings address of a register offset relative to a base.
   function automatic logic [7:0] sr_addr(input int base, input logic [7:0] off);
      return 8'(base) + off;
   endfunction

endpackage

// File: rtl/puf_capture_regs.sv
// Settings-bus decode: holds skip/length/timeout registers and turns
// control writes into single-cycle start/abort pulses.
module puf_capture_regs
   import puf_capture_ctrl_pkg::*;
#(
   parameter int CNT_WIDTH = 14,
   parameter int SR_BASE   = 0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 set_stb_i,
   input  logic [7:0]           set_addr_i,
   input  logic [31:0]          set_data_i,
   input  logic                 busy_i,
   output logic                 start_o,
   output logic                 abort_o,
   output logic [CNT_WIDTH-1:0] skip_len_o,
   output logic [CNT_WIDTH-1:0] cap_len_o,
   output logic [31:0]          drain_timeout_o
);

   logic                 ctrl_hit;
   logic                 skip_hit;
   logic                 len_hit;
   logic                 to_hit;
   logic [CNT_WIDTH-1:0] skip_len_q;
   logic [CNT_WIDTH-1:0] cap_len_q;
   logic [31:0]          drain_timeout_q;

   // Address decode of the current settings write.
   always_comb begin
      ctrl_hit = set_stb_i && (set_addr_i == sr_addr(SR_BASE, SR_CTRL));
      skip_hit = set_stb_i && (set_addr_i == sr_addr(SR_BASE, SR_SKIP));
      len_hit  = set_stb_i && (set_addr_i == sr_addr(SR_BASE, SR_LEN));
      to_hit   = set_stb_i && (set_addr_i == sr_addr(SR_BASE, SR_TIMEOUT));
   end

   // Control bits act only in the write cycle; abort dominates a combined write.
   assign abort_o = ctrl_hit & set_data_i[CTRL_ABORT_BIT];
   assign start_o = ctrl_hit & set_data_i[CTRL_START_BIT] & ~set_data_i[CTRL_ABORT_BIT];

   // Configuration registers, frozen while a run is in progress.
   always_ff @(posedge clk) begin
      if (reset) begin
         skip_len_q      <= '0;
         cap_len_q       <= '0;
         drain_timeout_q <= '0;
      end else if (!busy_i) begin
         if (skip_hit) skip_len_q      <= set_data_i[CNT_WIDTH-1:0];
         if (len_hit)  cap_len_q       <= set_data_i[CNT_WIDTH-1:0];
         if (to_hit)   drain_timeout_q <= set_data_i;
      end
   end

   assign skip_len_o      = skip_len_q;
   assign cap_len_o       = cap_len_q;
   assign drain_timeout_o = drain_timeout_q;

endmodule

// File: rtl/puf_capture_ctrl.sv
// Capture controller: skips a number of radio IQ beats, forwards a fixed
// window to the PUF datapath, then waits for the PUF result (or a timeout).
module puf_capture_ctrl
   import puf_capture_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int CNT_WIDTH  = 14,
   parameter int SR_BASE    = 0
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    set_stb,
   input  logic [7:0]              set_addr,
   input  logic [31:0]             set_data,
   input  logic [2*DATA_WIDTH-1:0] in_tdata,
   input  logic                    in_tvalid,
   input  logic                    in_tlast,
   output logic                    in_tready,
   output logic [2*DATA_WIDTH-1:0] puf_tdata,
   output logic                    puf_tvalid,
   output logic                    puf_tlast,
   input  logic                    puf_tready,
   input  logic                    res_tvalid,
   input  logic                    res_tlast,
   output logic                    res_tready,
   output logic                    busy,
   output logic                    done,
   output logic                    timeout,
   output logic [15:0]             res_count
);

   logic                 start;
   logic                 abort;
   logic [CNT_WIDTH-1:0] skip_len_r;
   logic [CNT_WIDTH-1:0] cap_len_r;
   logic [31:0]          drain_to_r;

   state_e               state_q;
   logic [CNT_WIDTH-1:0] skip_len_q;
   logic [CNT_WIDTH-1:0] cap_len_q;
   logic [31:0]          drain_to_q;
   logic [CNT_WIDTH-1:0] skip_cnt_q;
   logic [CNT_WIDTH-1:0] beat_cnt_q;
   logic [31:0]          timer_q;
   logic                 busy_q;
   logic                 done_q;
   logic                 timeout_q;
   logic [15:0]          res_count_q;

   logic                 capturing;
   logic                 cap_last;
   logic                 cap_hs;
   logic                 res_hs;
   logic                 unused_in_tlast;

   puf_capture_regs #(
      .CNT_WIDTH (CNT_WIDTH),
      .SR_BASE   (SR_BASE)
   ) u_regs (
      .clk             (clk),
      .reset           (reset),
      .set_stb_i       (set_stb),
      .set_addr_i      (set_addr),
      .set_data_i      (set_data),
      .busy_i          (busy_q),
      .start_o         (start),
      .abort_o         (abort),
      .skip_len_o      (skip_len_r),
      .cap_len_o       (cap_len_r),
      .drain_timeout_o (drain_to_r)
   );

   // The radio's own framing is irrelevant; the window length defines tlast.
   assign unused_in_tlast = in_tlast;

   // Zero-latency pass-through in CAPTURE; input is drained everywhere else.
   always_comb begin
      capturing  = (state_q == ST_CAPTURE);
      cap_last   = capturing && (beat_cnt_q == cap_len_q - 1'b1);
      cap_hs     = capturing && in_tvalid && puf_tready;
      res_hs     = res_tvalid;
      in_tready  = capturing ? puf_tready : 1'b1;
      puf_tvalid = capturing && in_tvalid;
      puf_tlast  = cap_last;
      puf_tdata  = in_tdata;
      res_tready = 1'b1;
   end

   // Main run sequencer with its counters and registered status flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         skip_len_q  <= '0;
         cap_len_q   <= '0;
         drain_to_q  <= '0;
         skip_cnt_q  <= '0;
         beat_cnt_q  <= '0;
         timer_q     <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         timeout_q   <= 1'b0;
         res_count_q <= '0;
      end else begin
         done_q <= 1'b0;

         if (res_hs && (state_q == ST_CAPTURE || state_q == ST_DRAIN) &&
             (res_count_q != 16'hFFFF)) begin
            res_count_q <= res_count_q + 16'd1;
         end

         if (abort) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (start && (cap_len_r != '0)) begin
                     skip_len_q  <= skip_len_r;
                     cap_len_q   <= cap_len_r;
                     drain_to_q  <= drain_to_r;
                     skip_cnt_q  <= '0;
                     beat_cnt_q  <= '0;
                     timer_q     <= '0;
                     res_count_q <= '0;
                     busy_q      <= 1'b1;
                     state_q     <= (skip_len_r != '0) ? ST_SKIP : ST_CAPTURE;
                  end
               end
               ST_SKIP: begin
                  if (in_tvalid) begin
                     if (skip_cnt_q == skip_len_q - 1'b1) begin
                        state_q <= ST_CAPTURE;
                     end else begin
                        skip_cnt_q <= skip_cnt_q + 1'b1;
                     end
                  end
               end
               ST_CAPTURE: begin
                  if (cap_hs) begin
                     if (cap_last) begin
                        state_q <= ST_DRAIN;
                        timer_q <= '0;
                     end else begin
                        beat_cnt_q <= beat_cnt_q + 1'b1;
                     end
                  end
               end
               ST_DRAIN: begin
                  // A result tlast in the same cycle as the timeout wins.
                  if (res_hs && res_tlast) begin
                     state_q   <= ST_DONE;
                     done_q    <= 1'b1;
                     busy_q    <= 1'b0;
                     timeout_q <= 1'b0;
                  end else if ((drain_to_q != '0) && (timer_q == drain_to_q - 32'd1)) begin
                     state_q   <= ST_DONE;
                     done_q    <= 1'b1;
                     busy_q    <= 1'b0;
                     timeout_q <= 1'b1;
                  end else if (timer_q != '1) begin
                     timer_q <= timer_q + 32'd1;
                  end
               end
               ST_DONE: begin
                  state_q <= ST_IDLE;
               end
               default: begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign timeout   = timeout_q;
   assign res_count = res_count_q;

endmodule

// File: tb/tb_puf_capture_ctrl.sv
// Directed bench for puf_capture_ctrl with an expected-beat scoreboard.
module tb_puf_capture_ctrl;
   import puf_capture_ctrl_pkg::*;

   localparam int DW = 16;
   localparam int TW = 2 * DW;

   logic          clk = 1'b0;
   logic          reset;
   logic          set_stb;
   logic [7:0]    set_addr;
   logic [31:0]   set_data;
   logic [TW-1:0] in_tdata;
   logic          in_tvalid;
   logic          in_tlast;
   logic          in_tready;
   logic [TW-1:0] puf_tdata;
   logic          puf_tvalid;
   logic          puf_tlast;
   logic          puf_tready;
   logic          res_tvalid;
   logic          res_tlast;
   logic          res_tready;
   logic          busy;
   logic          done;
   logic          timeout;
   logic [15:0]   res_count;

   int            n_total = 0;
   int            n_pass  = 0;
   logic [TW:0]   exp_q[$];
   logic [TW-1:0] src_val;
   int            beats_seen;
   int            done_cnt;
   logic          done_now;
   logic          mirror_chk;

   puf_capture_ctrl #(.DATA_WIDTH(DW), .CNT_WIDTH(14), .SR_BASE(0)) dut (
      .clk        (clk),
      .reset      (reset),
      .set_stb    (set_stb),
      .set_addr   (set_addr),
      .set_data   (set_data),
      .in_tdata   (in_tdata),
      .in_tvalid  (in_tvalid),
      .in_tlast   (in_tlast),
      .in_tready  (in_tready),
      .puf_tdata  (puf_tdata),
      .puf_tvalid (puf_tvalid),
      .puf_tlast  (puf_tlast),
      .puf_tready (puf_tready),
      .res_tvalid (res_tvalid),
      .res_tlast  (res_tlast),
      .res_tready (res_tready),
      .busy       (busy),
      .done       (done),
      .timeout    (timeout),
      .res_count  (res_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: sample outputs at negedge, then advance the source after the edge.
   task automatic tick();
      logic        src_hs;
      logic [TW:0] e;
      @(negedge clk);
      done_now = done;
      if (done) done_cnt++;
      if (mirror_chk) check("in_tready_mirror", 32'(in_tready), 32'(puf_tready));
      if (puf_tvalid === 1'b1 && puf_tready === 1'b1) begin
         beats_seen++;
         check("beat_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("puf_tdata", puf_tdata, e[TW-1:0]);
            check("puf_tlast", 32'(puf_tlast), 32'(e[TW]));
         end
      end
      src_hs = in_tvalid && in_tready;
      @(posedge clk);
      #1;
      if (src_hs) begin
         src_val  = src_val + 1;
         in_tdata = src_val;
      end
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d);
      set_stb  = 1'b1;
      set_addr = a;
      set_data = d;
      tick();
      set_stb  = 1'b0;
      set_addr = '0;
      set_data = '0;
   endtask

   task automatic push_beats(input int first, input int n, input int cap);
      for (int i = 0; i < n; i++) exp_q.push_back({1'(i == cap - 1), TW'(first + i)});
   endtask

   task automatic src_on();
      src_val   = 1;
      in_tdata  = 1;
      in_tvalid = 1'b1;
   endtask

   task automatic wait_beats(input string tag, input int target, input int budget);
      for (int c = 0; c < budget && beats_seen < target; c++) tick();
      check(tag, 32'(beats_seen), 32'(target));
   endtask

   task automatic wait_done(input string tag, input int budget);
      done_now = 1'b0;
      for (int c = 0; c < budget && !done_now; c++) tick();
      check(tag, 32'(done_now), 32'd1);
   endtask

   task automatic res_pulse();
      res_tvalid = 1'b1;
      res_tlast  = 1'b1;
      tick();
      res_tvalid = 1'b0;
      res_tlast  = 1'b0;
   endtask

   initial begin
      int n;
      int d0;
      reset = 1'b1; set_stb = 0; set_addr = 0; set_data = 0;
      in_tdata = 0; in_tvalid = 0; in_tlast = 0; puf_tready = 1;
      res_tvalid = 0; res_tlast = 0; src_val = 0;
      beats_seen = 0; done_cnt = 0; done_now = 0; mirror_chk = 0;
      repeat (3) tick();
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_timeout", 32'(timeout), 32'd0);
      check("rst_res_count", 32'(res_count), 32'd0);
      check("rst_puf_tvalid", 32'(puf_tvalid), 32'd0);
      check("rst_puf_tlast", 32'(puf_tlast), 32'd0);
      check("rst_res_tready", 32'(res_tready), 32'd1);
      reset = 1'b0;
      tick();

      // Skip 4, capture 8 with continuous valid/ready.
      wr(SR_SKIP, 4); wr(SR_LEN, 8); wr(SR_TIMEOUT, 0);
      beats_seen = 0; push_beats(5, 8, 8);
      wr(SR_CTRL, 1);
      check("t1_busy_start", 32'(busy), 32'd1);
      src_on();
      wait_beats("t1_beats", 8, 40);
      check("t1_queue_empty", 32'(exp_q.size()), 32'd0);
      check("t1_busy_drain", 32'(busy), 32'd1);
      in_tvalid = 1'b0;
      res_pulse();
      wait_done("t1_done", 5);
      check("t1_timeout", 32'(timeout), 32'd0);
      check("t1_busy_after", 32'(busy), 32'd0);

      // Capture 16 with puf_tready toggling and a 3-cycle stall.
      wr(SR_SKIP, 0); wr(SR_LEN, 16);
      beats_seen = 0; push_beats(1, 16, 16);
      wr(SR_CTRL, 1);
      src_on();
      mirror_chk = 1'b1;
      for (int c = 0; c < 80 && beats_seen < 16; c++) begin
         puf_tready = (c >= 8 && c < 11) ? 1'b0 : ((c % 2) == 0);
         tick();
      end
      mirror_chk = 1'b0; puf_tready = 1'b1; in_tvalid = 1'b0;
      check("t2_beats", 32'(beats_seen), 32'd16);
      check("t2_queue_empty", 32'(exp_q.size()), 32'd0);
      res_pulse();
      wait_done("t2_done", 5);

      // Drain timeout of 50 with no result tlast.
      wr(SR_LEN, 1); wr(SR_TIMEOUT, 50);
      beats_seen = 0; push_beats(1, 1, 1);
      wr(SR_CTRL, 1);
      src_on();
      wait_beats("t3_beats", 1, 10);
      in_tvalid = 1'b0;
      done_now = 1'b0;
      for (n = 0; n < 100; n++) begin
         tick();
         if (done_now) break;
      end
      check("t3_to_latency", 32'(n), 32'd50);
      check("t3_timeout_set", 32'(timeout), 32'd1);

      // Reset in the middle of a capture window.
      wr(SR_LEN, 8);
      beats_seen = 0; push_beats(1, 3, 8);
      wr(SR_CTRL, 1);
      src_on();
      res_tvalid = 1'b1;
      tick();
      res_tvalid = 1'b0;
      tick();
      check("t6_res_count_pre", 32'(res_count), 32'd1);
      reset = 1'b1;
      tick();
      check("t6_rst_busy", 32'(busy), 32'd0);
      check("t6_rst_timeout", 32'(timeout), 32'd0);
      check("t6_rst_res_count", 32'(res_count), 32'd0);
      check("t6_rst_puf_tvalid", 32'(puf_tvalid), 32'd0);
      check("t6_rst_puf_tlast", 32'(puf_tlast), 32'd0);
      check("t6_rst_in_tready", 32'(in_tready), 32'd1);
      check("t6_rst_beats", 32'(beats_seen), 32'd3);
      reset = 1'b0; in_tvalid = 1'b0;
      tick();
      // cap_len was cleared by reset, so this start must be ignored.
      wr(SR_CTRL, 1);
      check("t6_len0_ignored", 32'(busy), 32'd0);

      // Result tlast on drain cycle 49 beats the coincident timeout.
      wr(SR_LEN, 1); wr(SR_TIMEOUT, 50);
      beats_seen = 0; push_beats(1, 1, 1);
      wr(SR_CTRL, 1);
      src_on();
      wait_beats("t3b_beats", 1, 10);
      in_tvalid = 1'b0;
      done_now = 1'b0;
      for (n = 0; n < 100; n++) begin
         res_tvalid = (n == 49);
         res_tlast  = (n == 49);
         tick();
         if (done_now) break;
      end
      res_tvalid = 1'b0; res_tlast = 1'b0;
      check("t3b_latency", 32'(n), 32'd50);
      check("t3b_timeout_clr", 32'(timeout), 32'd0);
      check("t3b_res_count", 32'(res_count), 32'd1);

      // Four result beats, tlast on the fourth.
      wr(SR_LEN, 4); wr(SR_TIMEOUT, 0);
      beats_seen = 0; push_beats(1, 4, 4);
      wr(SR_CTRL, 1);
      check("t4_res_count_clr", 32'(res_count), 32'd0);
      src_on();
      wait_beats("t4_beats", 4, 20);
      in_tvalid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         res_tvalid = 1'b1;
         res_tlast  = (k == 3);
         tick();
      end
      res_tvalid = 1'b0; res_tlast = 1'b0;
      tick();
      check("t4_done", 32'(done_now), 32'd1);
      check("t4_res_count", 32'(res_count), 32'd4);

      // Abort while the fourth beat of a 10-beat window is handshaken.
      wr(SR_LEN, 10);
      beats_seen = 0; push_beats(1, 4, 10);
      wr(SR_CTRL, 1);
      src_on();
      wait_beats("t5_beats_pre", 3, 20);
      d0 = done_cnt;
      wr(SR_CTRL, 2);
      check("t5_abort_tvalid", 32'(puf_tvalid), 32'd0);
      check("t5_abort_busy", 32'(busy), 32'd0);
      repeat (4) tick();
      check("t5_no_done", 32'(done_cnt), 32'(d0));
      check("t5_beats", 32'(beats_seen), 32'd4);
      check("t5_queue_empty", 32'(exp_q.size()), 32'd0);
      in_tvalid = 1'b0;
      wr(SR_LEN, 2);
      beats_seen = 0; push_beats(1, 2, 2);
      wr(SR_CTRL, 1);
      src_on();
      wait_beats("t5_rerun_beats", 2, 20);
      in_tvalid = 1'b0;
      res_pulse();
      wait_done("t5_rerun_done", 5);

      // Start and length writes while busy are ignored.
      wr(SR_LEN, 5);
      beats_seen = 0; push_beats(1, 5, 5);
      wr(SR_CTRL, 1);
      wr(SR_LEN, 3);
      wr(SR_CTRL, 1);
      check("t6_busy_hold", 32'(busy), 32'd1);
      src_on();
      wait_beats("t6_beats", 5, 30);
      check("t6_queue_empty", 32'(exp_q.size()), 32'd0);
      in_tvalid = 1'b0;
      res_pulse();
      wait_done("t6_done", 5);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
